arith_engine_driver: RTL

//  Sequential front end for the combinational arithmetic engine (A, B, opcode -> result).

---
 rtl/arith_engine_driver_if.sv | 24 ++
 rtl/arith_engine_driver.sv | 81 ++++++++
 2 files changed

// File: rtl/arith_engine_driver_if.sv
// arith_engine_driver_if: command and response valid/ready channels between a command source and the driver.
interface arith_engine_driver_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [2:0]        cmd_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_carry;
    logic              rsp_zero;
    logic              rsp_illegal;
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/arith_engine_driver.sv
// arith_engine_driver: registers a command onto a combinational arithmetic engine, waits a settle time, and returns the sampled result with flags.
module arith_engine_driver #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arith_engine_driver_if.slave bus,
    output logic [DATA_W-1:0]    eng_a,
    output logic [DATA_W-1:0]    eng_b,
    output logic [2:0]           eng_op,
    input  logic [DATA_W-1:0]    eng_result,
    output logic [CNT_W-1:0]     txn_count
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
    state_t            state, state_nx;
    logic [SW-1:0]     cnt;
    logic              carry_q, illegal_q;
    logic              accept, sample, done;
    logic [DATA_W:0]   sum;
    logic              carry_pre, illegal_pre;
    logic [DATA_W-1:0] result_pre;
    assign accept          = bus.cmd_valid && bus.cmd_ready;
    assign sample          = state == SETTLE && cnt == '0;
    assign done            = state == RESP && bus.rsp_ready;
    assign bus.cmd_ready   = rst_n && state == IDLE;
    assign bus.rsp_valid   = state == RESP;
    // flags depend only on the operands, so they are fixed at accept time
    assign sum         = {1'b0, bus.cmd_a} + {1'b0, bus.cmd_b};
    assign illegal_pre = &bus.cmd_op[2:1];
    assign carry_pre   = bus.cmd_op == 3'd4 ? sum[DATA_W] :
                         bus.cmd_op == 3'd5 ? bus.cmd_a < bus.cmd_b : 1'b0;
    assign result_pre  = illegal_q ? '0 : eng_result;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? SETTLE : IDLE;
            SETTLE:  state_nx = sample ? RESP : SETTLE;
            RESP:    state_nx = done ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_a           <= '0;
            eng_b           <= '0;
            eng_op          <= '0;
            cnt             <= '0;
            carry_q         <= 1'b0;
            illegal_q       <= 1'b0;
            bus.rsp_result  <= '0;
            bus.rsp_carry   <= 1'b0;
            bus.rsp_zero    <= 1'b0;
            bus.rsp_illegal <= 1'b0;
            txn_count       <= '0;
        end else begin
            if (accept) begin
                eng_a     <= bus.cmd_a;
                eng_b     <= bus.cmd_b;
                eng_op    <= bus.cmd_op;
                carry_q   <= carry_pre;
                illegal_q <= illegal_pre;
                cnt       <= SW'(SETTLE_CYCLES - 1);
            end
            if (state == SETTLE && !sample) cnt <= cnt - 1'b1;
            if (sample) begin
                bus.rsp_result  <= result_pre;
                bus.rsp_zero    <= result_pre == '0;
                bus.rsp_carry   <= carry_q;
                bus.rsp_illegal <= illegal_q;
            end
            if (done) txn_count <= txn_count + 1'b1;
        end
    end
endmodule
